// File: rtl/func_32b_accum_pkg.sv
// Shared constants for the accumulator microbench: default widths and FSM state encodings.
package func_32b_accum_pkg;

  localparam int unsigned SIZE_DEF  = 32;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/func_32b_add_sub.sv
// Combinational add/subtract unit with two's-complement signed overflow detect.
module func_32b_add_sub #(
  parameter int unsigned size = 32
) (
  input  logic [size-1:0] in_a,
  input  logic [size-1:0] in_b,
  input  logic            select,
  output logic [size-1:0] out,
  output logic            ovf
);

  logic [size-1:0] w_b_eff;

  // Subtraction as a + ~b + 1 so one adder covers both operations.
  assign w_b_eff = select ? ~in_b : in_b;
  assign out     = in_a + w_b_eff + size'(select);
  assign ovf     = (in_a[size-1] == w_b_eff[size-1]) && (out[size-1] != in_a[size-1]);

endmodule

// File: rtl/func_32b_accum.sv
// Seeded add/subtract reduction over a counted stream of terms with sticky signed overflow.
module func_32b_accum
  import func_32b_accum_pkg::*;
#(
  parameter int unsigned size  = SIZE_DEF,
  parameter int unsigned cnt_w = CNT_W_DEF
) (
  input  logic             CGRA_Clock,
  input  logic             CGRA_Reset,
  input  logic             start,
  input  logic [cnt_w-1:0] count,
  input  logic [size-1:0]  in_b,
  input  logic [size-1:0]  in_a,
  input  logic             select,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [size-1:0]  out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [size-1:0]   r_acc;
  logic [size-1:0]   w_acc_nxt;
  logic [cnt_w-1:0]  r_rem;
  logic [cnt_w-1:0]  w_rem_nxt;
  logic              r_ovf;
  logic              w_ovf_nxt;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [size-1:0]   w_sum;
  logic              w_sum_ovf;

  func_32b_add_sub #(
    .size (size)
  ) u_add_sub (
    .in_a   (r_acc),
    .in_b   (in_a),
    .select (select),
    .out    (w_sum),
    .ovf    (w_sum_ovf)
  );

  always_ff @(posedge CGRA_Clock) begin
    if (!CGRA_Reset) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_rem       <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_rem       <= w_rem_nxt;
      r_ovf       <= w_ovf_nxt;
      r_in_ready  <= (w_state_nxt == ST_ACCUM);
      r_out_valid <= (w_state_nxt == ST_DONE);
    end
  end

  // Next-state and datapath update; unlisted conditions hold every register.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_rem_nxt   = r_rem;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_acc_nxt   = in_b;
          w_rem_nxt   = count;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = (count == '0) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (in_valid) begin
          w_acc_nxt = w_sum;
          w_rem_nxt = r_rem - cnt_w'(1);
          w_ovf_nxt = r_ovf | w_sum_ovf;
          if (r_rem == cnt_w'(1)) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out       = r_acc;
  assign ovf       = r_ovf;

endmodule

// File: doc/func_32b_accum.md
FUNC_32B_ACCUM -- requirements
Module: func_32b_accum

Interface
REQ-001 Parameter: size, default 32, datapath width in bits.
REQ-002 Parameter: cnt_w, default 8, width of the term-count input.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset.
REQ-004 CGRA_Clock  input  1  clock; all state updates on rising edge.
REQ-005 CGRA_Reset  input  1  synchronous, active-low reset.
REQ-006 start  input  1  begin a reduction; honoured only in IDLE.
REQ-007 count  input  cnt_w  number of terms to consume; sampled with start.
REQ-008 in_b  input  size  seed value; sampled with start.
REQ-009 in_a  input  size  term operand.
REQ-010 select  input  1  per-term op: 0 = add, 1 = subtract; sampled with each accepted term.
REQ-011 in_valid  input  1  in_a/select valid.
REQ-012 in_ready  output  1  block accepts a term this cycle.
REQ-013 out  output  size  accumulated result.
REQ-014 out_valid  output  1  out holds the final result.
REQ-015 out_ready  input  1  consumer takes the result.
REQ-016 ovf  output  1  sticky signed overflow flag for the current reduction.

Function
REQ-017 States SHALL be IDLE, ACCUM and DONE.
REQ-018 IDLE: in_ready=0, out_valid=0; when start=1, acc<=in_b, remaining<=count, ovf<=0.
REQ-019 From IDLE with start=1: count=0 -> DONE; otherwise -> ACCUM.
REQ-020 ACCUM: in_ready=1; a term is accepted when in_valid=1 and in_ready=1.
REQ-021 On acceptance: acc <= acc+in_a (select=0) or acc-in_a (select=1), modulo 2^size; remaining decrements by 1.
REQ-022 Signed overflow of an accepted operation SHALL set ovf; ovf stays set until the next start in IDLE.
REQ-023 When the accepted term has remaining=1, the next state SHALL be DONE; otherwise stay in ACCUM.
REQ-024 A cycle with in_valid=0 in ACCUM SHALL leave all state unchanged.
REQ-025 DONE: out_valid=1 and in_ready=0; out and ovf are held stable until out_ready=1.
REQ-026 DONE with out_ready=1 SHALL transition to IDLE on the next edge; out_valid=0 in IDLE.
REQ-027 out SHALL equal acc in every state, with no combinational path from in_a to out.
REQ-028 start outside IDLE SHALL be ignored.
REQ-029 The result SHALL be visible (out_valid=1) one cycle after the last term is accepted; a count=0 result is visible one cycle after start.
REQ-030 The acceptance rate in ACCUM SHALL be one term per cycle under continuous in_valid.

Reset
REQ-031 With CGRA_Reset=0 at a rising edge: state=IDLE, acc=0, remaining=0, ovf=0; therefore out=0, out_valid=0, in_ready=0.
REQ-032 Reset mid-ACCUM or mid-DONE SHALL abandon the reduction with no result emitted.
REQ-033 Reset SHALL take priority over start, term acceptance and out_ready in the same cycle.

Structure
REQ-034 State encodings (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2) and the default size/cnt_w values SHALL live in the shared microbench constants include.
REQ-035 The add/subtract datapath SHALL be one instance of the existing func_32b_add_sub unit (in_a=acc, in_b=term, select); the FSM, counter and registers SHALL be local.

Verification
REQ-036 Seed 10, count 3, terms +5, +7, -2 back-to-back -> out=20, out_valid 1 cycle after the third acceptance, ovf=0.
REQ-037 count=0, seed 0x1234 -> DONE next cycle, out=0x1234, in_ready never asserted.
REQ-038 Seed 0x7FFFFFFF, count 1, +1 -> out=0x80000000, ovf=1; the next start clears ovf.
REQ-039 count 2 with in_valid gaps of 3 cycles and out_ready held low 5 cycles -> acc unchanged during gaps, out and out_valid stable until out_ready.
REQ-040 Reset asserted after 1 of 4 terms -> IDLE, out=0; a new start with seed 0 and count 1, term 9 -> out=9.
REQ-041 start pulsed during ACCUM and DONE -> no effect on acc, remaining or state.
